// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I execute-stage ALU.
//   XLEN          : datapath width (fixed at 32)
//   alu_op_e      : 4-bit ALU function codes
//   shift_mode_e  : operating mode of the barrel shifter
//   bit_reverse() : mirrors a word end-for-end; lets one right-shifting
//                   datapath also perform left shifts
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SLTU  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational 32-bit barrel shifter built as a 5-stage logarithmic shifter.
// Stage i shifts right by 2**i when shamt[i] is set. Left shifts reuse the
// same right-shifting stages by mirroring the word on the way in and out.
//   data   : input  [XLEN-1:0]  value to shift
//   shamt  : input  [4:0]       shift amount
//   mode   : input  shift_mode_e SLL / SRL / SRA
//   result : output [XLEN-1:0]  shifted value
// -----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  shift_mode_e     mode,
    output logic [XLEN-1:0] result
);

    logic            is_left;
    logic            fill_bit;
    logic [XLEN-1:0] stage_in;
    logic [XLEN-1:0] stage_out;

    assign is_left  = (mode == SH_SLL);
    // Only arithmetic right shifts replicate the sign; a mirrored left shift
    // must shift in zeros, which the zero fill provides.
    assign fill_bit = (mode == SH_SRA) & data[XLEN-1];
    assign stage_in = is_left ? bit_reverse(data) : data;

    always_comb begin
        logic [2*XLEN-1:0] ext;
        stage_out = stage_in;
        for (int i = 0; i < 5; i++) begin
            // Extend with the fill bit above the word so shifted-in bits
            // come from the fill, then keep the low XLEN bits.
            ext = {{XLEN{fill_bit}}, stage_out} >> (1 << i);
            if (shamt[i]) begin
                stage_out = ext[XLEN-1:0];
            end
        end
    end

    assign result = is_left ? bit_reverse(stage_out) : stage_out;

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// 32-bit RV32I execute-stage ALU with a single registered output stage.
// Result and flags appear one clock after x/y/ALUFn are sampled; a new
// operation is accepted every cycle.
//   clk      : input        rising-edge clock
//   rst_n    : input        synchronous active-low reset
//   x        : input  [31]  operand A (rs1)
//   y        : input  [31]  operand B (rs2 / immediate)
//   ALUFn    : input  [3:0] operation select (alu_op_e)
//   out      : output [31]  registered result
//   zero     : output       registered, result == 0
//   ng       : output       registered, result bit 31
//   overflow : output       registered signed overflow (ADD/SUB only)
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       ALUFn,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ng,
    output logic             overflow
);

    alu_op_e         op;
    logic [XLEN-1:0] sum;
    logic [XLEN:0]   diff_u;
    logic            lt_u;
    logic            lt_s;
    logic            add_ovf;
    logic            sub_ovf;
    shift_mode_e     sh_mode;
    logic [XLEN-1:0] sh_result;

    logic [XLEN-1:0] out_d, out_q;
    logic            zero_d, zero_q;
    logic            ng_d, ng_q;
    logic            ovf_d, ovf_q;

    assign op  = alu_op_e'(ALUFn);
    assign sum = x + y;

    // 33-bit unsigned difference: low bits are the SUB result, the top bit
    // is the borrow, i.e. x <u y.
    assign diff_u = {1'b0, x} - {1'b0, y};
    assign lt_u   = diff_u[XLEN];
    // The 33-bit sign-extended difference differs from the zero-extended one
    // only in bit 32, flipped by x[31]^y[31]; its sign gives signed x < y,
    // correct even at the extremes where the 32-bit SUB result overflows.
    assign lt_s   = diff_u[XLEN] ^ x[XLEN-1] ^ y[XLEN-1];

    assign add_ovf = (x[XLEN-1] == y[XLEN-1]) && (sum[XLEN-1] != x[XLEN-1]);
    assign sub_ovf = (x[XLEN-1] != y[XLEN-1]) && (diff_u[XLEN-1] != x[XLEN-1]);

    always_comb begin
        sh_mode = SH_SLL;
        if (op == ALU_SRL) begin
            sh_mode = SH_SRL;
        end else if (op == ALU_SRA) begin
            sh_mode = SH_SRA;
        end
    end

    alu_shifter u_shifter (
        .data   (x),
        .shamt  (y[4:0]),
        .mode   (sh_mode),
        .result (sh_result)
    );

    always_comb begin
        out_d = '0;
        ovf_d = 1'b0;
        case (op)
            ALU_AND:   out_d = x & y;
            ALU_OR:    out_d = x | y;
            ALU_ADD: begin
                out_d = sum;
                ovf_d = add_ovf;
            end
            ALU_XOR:   out_d = x ^ y;
            ALU_SLL:   out_d = sh_result;
            ALU_SLTU:  out_d = {{(XLEN-1){1'b0}}, lt_u};
            ALU_SUB: begin
                out_d = diff_u[XLEN-1:0];
                ovf_d = sub_ovf;
            end
            ALU_SLT:   out_d = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SRL:   out_d = sh_result;
            ALU_SRA:   out_d = sh_result;
            ALU_PASSB: out_d = y;
            default:   out_d = '0;
        endcase
        zero_d = (out_d == '0);
        ng_d   = out_d[XLEN-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            zero_q <= 1'b1;
            ng_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
            ng_q   <= ng_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out      = out_q;
    assign zero     = zero_q;
    assign ng       = ng_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Directed vectors with hand-computed expectations, plus a behavioural
// reference that predicts every registered output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  ALUFn;
    logic [31:0] out;
    logic        zero;
    logic        ng;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Expected registered outputs, updated on every rising edge.
    logic        exp_valid = 1'b0;
    logic [31:0] exp_out;
    logic [2:0]  exp_flags;

    alu_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .y        (y),
        .ALUFn    (ALUFn),
        .out      (out),
        .zero     (zero),
        .ng       (ng),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference ALU using plain integer arithmetic.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic v);
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        v  = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                r    = a + b;
                wide = sa + sb;
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = a << b[4:0];
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6: begin
                r    = a - b;
                wide = sa - sb;
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = a >> b[4:0];
            4'd9:  r = 32'($signed(a) >>> b[4:0]);
            4'd10: r = b;
            default: r = 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] r;
        logic        v;
        if (!rst_n) begin
            exp_out   = 32'h0;
            exp_flags = 3'b100;
            exp_valid = 1'b1;
        end else if (exp_valid) begin
            ref_alu(ALUFn, x, y, r, v);
            exp_out   = r;
            exp_flags = {(r == 32'h0), r[31], v};
        end
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("model_out", out, exp_out);
            chk("model_flags", {29'h0, zero, ng, overflow}, {29'h0, exp_flags});
        end
    end

    // Drive one operation; check the hand-computed result one cycle later.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic [2:0] ef);
        @(negedge clk);
        ALUFn = op;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        $display("txn %-12s op=%h x=%h y=%h -> out=%h z=%b n=%b v=%b", name, op, a, b,
                 out, zero, ng, overflow);
        chk({name, "_out"}, out, eo);
        chk({name, "_flags"}, {29'h0, zero, ng, overflow}, {29'h0, ef});
    endtask

    initial begin
        rst_n = 1'b0;
        ALUFn = 4'd2;
        x     = 32'hDEADBEEF;
        y     = 32'h12345678;

        // Two reset cycles with arbitrary operands.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            $display("txn reset%0d out=%h z=%b n=%b v=%b", i, out, zero, ng, overflow);
            chk("reset_out", out, 32'h0);
            chk("reset_flags", {29'h0, zero, ng, overflow}, 32'h4);
        end
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_1_1",    4'd2,  32'h00000001, 32'h00000001, 32'h00000002, 3'b000);
        issue("add_ovf",    4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b011);
        issue("add_wrap",   4'd2,  32'h80000000, 32'h80000000, 32'h00000000, 3'b101);
        issue("sub_13_2",   4'd6,  32'h00000013, 32'h00000002, 32'h00000011, 3'b000);
        issue("sub_5_5",    4'd6,  32'h00000005, 32'h00000005, 32'h00000000, 3'b100);
        issue("sub_ovf",    4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b001);
        issue("sub_ovf2",   4'd6,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 3'b011);
        issue("and",        4'd0,  32'h00000001, 32'h00000000, 32'h00000000, 3'b100);
        issue("or",         4'd1,  32'h00000001, 32'h00000000, 32'h00000001, 3'b000);
        issue("xor",        4'd3,  32'h00000001, 32'h00000000, 32'h00000001, 3'b000);
        issue("sll_3",      4'd4,  32'h00000001, 32'h00000003, 32'h00000008, 3'b000);
        issue("srl_3",      4'd8,  32'h00000010, 32'h00000003, 32'h00000002, 3'b000);
        issue("sra_4",      4'd9,  32'h80000000, 32'h00000004, 32'hF8000000, 3'b010);
        issue("sra_31",     4'd9,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 3'b010);
        issue("sra_0",      4'd9,  32'h80000001, 32'h00000000, 32'h80000001, 3'b010);
        issue("sll_y23",    4'd4,  32'h00000001, 32'h00000023, 32'h00000008, 3'b000);
        issue("srl_hi",     4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 3'b000);
        issue("slt_neg",    4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b000);
        issue("sltu_neg",   4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b100);
        issue("slt_ext",    4'd7,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 3'b000);
        issue("sltu_ext",   4'd5,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 3'b000);
        issue("slt_eq",     4'd7,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 3'b100);
        issue("passb",      4'd10, 32'h00000000, 32'h12345000, 32'h12345000, 3'b000);
        issue("undef_f",    4'd15, 32'h00000005, 32'h00000006, 32'h00000000, 3'b100);
        issue("undef_b",    4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b100);

        // Reset overrides an operation in flight.
        @(negedge clk);
        rst_n = 1'b0;
        ALUFn = 4'd2;
        x     = 32'h00000009;
        y     = 32'h80000000;
        @(posedge clk);
        #1;
        $display("txn mid_reset out=%h z=%b n=%b v=%b", out, zero, ng, overflow);
        chk("midrst_out", out, 32'h0);
        chk("midrst_flags", {29'h0, zero, ng, overflow}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst",   4'd2,  32'h00000003, 32'h00000004, 32'h00000007, 3'b000);

        // Back-to-back pseudo-random operations, checked by the reference.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ALUFn = 4'($urandom_range(0, 15));
            x     = $urandom;
            y     = (i % 4 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            $display("txn rand%0d op=%h x=%h y=%h", i, ALUFn, x, y);
        end
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
